// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter unit and anything else that
// needs the trap-vector arithmetic (e.g. the CSR block).
//   state_t          : redirect-buffer FSM states (IDLE, PEND)
//   MTVEC_VECTORED   : mtvec[1:0] encoding that selects vectored trap mode
//   trap_target()    : trap target from mtvec / interrupt flag / cause code
// -----------------------------------------------------------------------------
package pc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   // Computed at 64 bits so one function serves any XLEN up to 64; callers
   // truncate the result back to their own width (the arithmetic wraps the
   // same way either way).
   function automatic logic [63:0] trap_target(input logic [63:0] mtvec,
                                               input logic        intr,
                                               input logic [4:0]  cause);
      logic [63:0] base;
      base = {mtvec[63:2], 2'b00};
      if (intr && (mtvec[1:0] == MTVEC_VECTORED)) begin
         return base + {57'd0, cause, 2'b00};
      end
      return base;
   endfunction

endpackage

// File: rtl/pc_trap_vec.sv
// -----------------------------------------------------------------------------
// pc_trap_vec
// Purely combinational trap-target calculation.
//   mtvec  in  XLEN  trap base; [1:0]=01 selects vectored mode
//   intr   in  1     trap is an interrupt
//   cause  in  5     cause code
//   target out XLEN  base, or base + cause*4 for vectored interrupts
// -----------------------------------------------------------------------------
module pc_trap_vec
   import pc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] mtvec,
   input  logic            intr,
   input  logic [4:0]      cause,
   output logic [XLEN-1:0] target
);

   assign target = XLEN'(trap_target(64'(mtvec), intr, cause));

endmodule

// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
// Owns the PC register and chooses the next PC from PC+4, an N-way target bus
// or the trap vector. A redirect requested while the pipeline is stalled is
// held in a one-entry buffer and applied on the first advancing cycle.
// Misaligned targets and out-of-range selects are rejected with a one-cycle
// pulse. All outputs come from registers (PC_4 adds only the +4 adder).
//
//   clk         in   1             rising-edge clock
//   rst_n       in   1             asynchronous active-low reset
//   pc_write    in   1             advance enable; 0 = stall
//   pc_source   in   clog2(NSRC)   target select; 0 = PC+4
//   targets     in   NSRC*XLEN     flattened targets, slice 0 unused
//   trap_req    in   1             take trap this cycle
//   trap_intr   in   1             trap is an interrupt
//   trap_cause  in   5             cause code
//   mtvec       in   XLEN          trap base / mode
//   flush       in   1             discard buffered redirect
//   pc          out  XLEN          current PC
//   pc_4        out  XLEN          PC+4 (wraps)
//   epc         out  XLEN          PC captured at the last trap
//   misalign    out  1             pulse: misaligned target rejected
//   sel_err     out  1             pulse: pc_source >= NSRC
//   bad_addr    out  XLEN          last rejected target
//   pend_valid  out  1             a redirect is buffered
// -----------------------------------------------------------------------------
module pc_next_unit
   import pc_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter int              NSRC       = 6,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              ALIGN_BITS = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pc_write,
   input  logic [$clog2(NSRC)-1:0]   pc_source,
   input  logic [NSRC*XLEN-1:0]      targets,
   input  logic                      trap_req,
   input  logic                      trap_intr,
   input  logic [4:0]                trap_cause,
   input  logic [XLEN-1:0]           mtvec,
   input  logic                      flush,
   output logic [XLEN-1:0]           pc,
   output logic [XLEN-1:0]           pc_4,
   output logic [XLEN-1:0]           epc,
   output logic                      misalign,
   output logic                      sel_err,
   output logic [XLEN-1:0]           bad_addr,
   output logic                      pend_valid
);

   localparam int SRC_W = $clog2(NSRC);

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   pend_q, pend_d;
   logic [XLEN-1:0]   epc_q, epc_d;
   logic [XLEN-1:0]   bad_q, bad_d;
   logic              mis_q, mis_d;
   logic              sel_q, sel_d;

   logic [XLEN-1:0]   tgt;
   logic [XLEN-1:0]   trap_tgt;
   logic [XLEN-1:0]   pc_plus4;
   logic              src_ok;
   logic              tgt_misaligned;

   pc_trap_vec #(.XLEN(XLEN)) u_trap_vec (
      .mtvec  (mtvec),
      .intr   (trap_intr),
      .cause  (trap_cause),
      .target (trap_tgt)
   );

   assign pc_plus4 = pc_q + XLEN'(4);

   // Loop-based select so an out-of-range pc_source never indexes past the
   // bus; it just leaves tgt at zero (and src_ok flags it).
   always_comb begin
      tgt = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (pc_source == SRC_W'(i)) begin
            tgt = targets[i*XLEN +: XLEN];
         end
      end
   end

   assign src_ok         = (int'(pc_source) < NSRC);
   assign tgt_misaligned = (tgt[ALIGN_BITS-1:0] != '0);

   // NOTE: every variable gets a default before the branches so no path can
   // leave one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      epc_d   = epc_q;
      bad_d   = bad_q;
      mis_d   = 1'b0;
      sel_d   = 1'b0;

      if (trap_req) begin
         // Trap overrides stalls and any buffered redirect.
         pc_d    = trap_tgt;
         epc_d   = pc_q;
         state_d = IDLE;
      end else if ((state_q == PEND) && !flush) begin
         // Buffered redirect: pc_source is ignored until the stall lifts.
         if (pc_write) begin
            pc_d    = pend_q;
            state_d = IDLE;
         end
      end else begin
         // IDLE rules (also used on a flush, which drops the buffer and
         // blocks a new capture in the same cycle).
         state_d = IDLE;
         if (!src_ok) begin
            sel_d = 1'b1;
         end else if (pc_source == '0) begin
            if (pc_write) begin
               pc_d = pc_plus4;
            end
         end else if (tgt_misaligned) begin
            bad_d = tgt;
            mis_d = 1'b1;
         end else if (pc_write) begin
            pc_d = tgt;
         end else if (!flush) begin
            pend_d  = tgt;
            state_d = PEND;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
         bad_q   <= '0;
         mis_q   <= 1'b0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         bad_q   <= bad_d;
         mis_q   <= mis_d;
         sel_q   <= sel_d;
      end
   end

   // NOTE: the pending address is only meaningful while state_q == PEND, and
   // reset forces IDLE, so this data register needs no reset.
   always_ff @(posedge clk) begin
      pend_q <= pend_d;
   end

   assign pc         = pc_q;
   assign pc_4       = pc_plus4;
   assign epc        = epc_q;
   assign misalign   = mis_q;
   assign sel_err    = sel_q;
   assign bad_addr   = bad_q;
   assign pend_valid = (state_q == PEND);

endmodule

// File: tb/tb_pc_next_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_next_unit
// Self-checking bench for pc_next_unit (XLEN=32, NSRC=6, RESET_PC=0,
// ALIGN_BITS=2). Each test task drives stimulus, pushes the expected outputs
// to a scoreboard queue and pops/compares them once the edge has happened.
// -----------------------------------------------------------------------------
module tb_pc_next_unit;

   localparam int XLEN = 32;
   localparam int NSRC = 6;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        pend;
      logic        mis;
      logic        sel;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 pc_write = 1'b0;
   logic [2:0]           pc_source = '0;
   logic [NSRC*XLEN-1:0] targets = '0;
   logic                 trap_req = 1'b0;
   logic                 trap_intr = 1'b0;
   logic [4:0]           trap_cause = '0;
   logic [31:0]          mtvec = '0;
   logic                 flush = 1'b0;
   logic [31:0]          pc, pc_4, epc, bad_addr;
   logic                 misalign, sel_err, pend_valid;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e;

   pc_next_unit #(
      .XLEN(XLEN), .NSRC(NSRC), .RESET_PC(32'h0), .ALIGN_BITS(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_write   (pc_write),
      .pc_source  (pc_source),
      .targets    (targets),
      .trap_req   (trap_req),
      .trap_intr  (trap_intr),
      .trap_cause (trap_cause),
      .mtvec      (mtvec),
      .flush      (flush),
      .pc         (pc),
      .pc_4       (pc_4),
      .epc        (epc),
      .misalign   (misalign),
      .sel_err    (sel_err),
      .bad_addr   (bad_addr),
      .pend_valid (pend_valid)
   );

   always #5 clk = ~clk;

   // Advance one edge; sample 1 time unit later, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_target(input int idx, input logic [31:0] val);
      targets[idx*XLEN +: XLEN] = val;
   endtask

   task automatic drive(input logic w, input logic [2:0] src);
      pc_write  = w;
      pc_source = src;
   endtask

   // Put the PC at a known address through source 1.
   task automatic load_pc(input logic [31:0] addr);
      trap_req = 1'b0;
      flush    = 1'b0;
      set_target(1, addr);
      drive(1'b1, 3'd1);
      tick();
      drive(1'b0, 3'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({pc, pc_4, epc, bad_addr, misalign, sel_err, pend_valid} !==
          {32'h0, 32'h4, 32'h0, 32'h0, 3'b000}) begin
         errors++;
         $display("FAIL reset_values: pc=%h pc_4=%h epc=%h bad=%h mis=%b sel=%b pend=%b, expected 0 4 0 0 0 0 0",
                  pc, pc_4, epc, bad_addr, misalign, sel_err, pend_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 3'd0);
      for (int k = 1; k <= 3; k++) begin
         sb.push_back('{"seq_count", 32'(4 * k), 1'b0, 1'b0, 1'b0});
         tick();
         e = sb.pop_front();
         checks++;
         if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
            errors++;
            $display("FAIL %s: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                     e.tag, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
         end
      end
   endtask

   task automatic test_stall_redirect();
      load_pc(32'h100);
      set_target(2, 32'h400);
      set_target(3, 32'h800);
      // step 0: stall + source 2 captures; step 1: source 3 ignored;
      // step 2: advance applies the buffered 0x400.
      for (int s = 0; s < 3; s++) begin
         case (s)
            0: begin drive(1'b0, 3'd2); sb.push_back('{"stall_capture", 32'h100, 1'b1, 1'b0, 1'b0}); end
            1: begin drive(1'b0, 3'd3); sb.push_back('{"stall_ignore_src", 32'h100, 1'b1, 1'b0, 1'b0}); end
            default: begin drive(1'b1, 3'd3); sb.push_back('{"pend_release", 32'h400, 1'b0, 1'b0, 1'b0}); end
         endcase
         tick();
         e = sb.pop_front();
         checks++;
         if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
            errors++;
            $display("FAIL %s: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                     e.tag, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
         end
      end
   endtask

   task automatic test_misalign();
      load_pc(32'h100);
      set_target(1, 32'h202);
      set_target(2, 32'h306);
      for (int s = 0; s < 3; s++) begin
         case (s)
            0: begin drive(1'b1, 3'd1); sb.push_back('{"misalign_jump", 32'h100, 1'b0, 1'b1, 1'b0}); end
            1: begin drive(1'b0, 3'd0); sb.push_back('{"misalign_pulse_end", 32'h100, 1'b0, 1'b0, 1'b0}); end
            default: begin drive(1'b0, 3'd2); sb.push_back('{"misalign_no_capture", 32'h100, 1'b0, 1'b1, 1'b0}); end
         endcase
         tick();
         e = sb.pop_front();
         checks++;
         if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
            errors++;
            $display("FAIL %s: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                     e.tag, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
         end
         if (s == 0) begin
            checks++;
            if (bad_addr !== 32'h202) begin
               errors++;
               $display("FAIL bad_addr_jump: bad_addr=%h, expected 00000202", bad_addr);
            end
         end
      end
      checks++;
      if (bad_addr !== 32'h306) begin
         errors++;
         $display("FAIL bad_addr_stall: bad_addr=%h, expected 00000306", bad_addr);
      end
      drive(1'b0, 3'd0);
   endtask

   task automatic test_trap();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_epc [3];
      exp_pc  = '{32'h101C, 32'h1000, 32'h3000};
      exp_epc = '{32'h50, 32'h50, 32'h50};
      for (int s = 0; s < 3; s++) begin
         load_pc(32'h50);
         trap_req   = 1'b1;
         trap_cause = 5'd7;
         case (s)
            0: begin mtvec = 32'h1001; trap_intr = 1'b1; drive(1'b1, 3'd0); end
            1: begin mtvec = 32'h1001; trap_intr = 1'b0; drive(1'b0, 3'd0); end
            default: begin mtvec = 32'h3000; trap_intr = 1'b1; drive(1'b0, 3'd1); end
         endcase
         sb.push_back('{"trap_target", exp_pc[s], 1'b0, 1'b0, 1'b0});
         tick();
         trap_req = 1'b0;
         e = sb.pop_front();
         checks++;
         if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
            errors++;
            $display("FAIL %s[%0d]: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                     e.tag, s, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
         end
         checks++;
         if (epc !== exp_epc[s]) begin
            errors++;
            $display("FAIL trap_epc[%0d]: epc=%h, expected %h", s, epc, exp_epc[s]);
         end
      end
      trap_intr = 1'b0;
   endtask

   task automatic test_simultaneous();
      load_pc(32'h200);
      set_target(1, 32'h600);
      set_target(2, 32'h400);
      mtvec     = 32'h2000;
      trap_intr = 1'b0;
      for (int s = 0; s < 3; s++) begin
         case (s)
            0: begin drive(1'b0, 3'd2); sb.push_back('{"sim_capture", 32'h200, 1'b1, 1'b0, 1'b0}); end
            1: begin
               trap_req = 1'b1; flush = 1'b1; drive(1'b1, 3'd1);
               sb.push_back('{"sim_trap_wins", 32'h2000, 1'b0, 1'b0, 1'b0});
            end
            default: begin
               trap_req = 1'b0; flush = 1'b0; drive(1'b1, 3'd0);
               sb.push_back('{"sim_buffer_gone", 32'h2004, 1'b0, 1'b0, 1'b0});
            end
         endcase
         tick();
         e = sb.pop_front();
         checks++;
         if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
            errors++;
            $display("FAIL %s: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                     e.tag, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
         end
      end
      checks++;
      if (epc !== 32'h200) begin
         errors++;
         $display("FAIL sim_epc: epc=%h, expected 00000200", epc);
      end
   endtask

   task automatic test_flush();
      // PC is 0x2004 on entry.
      for (int s = 0; s < 3; s++) begin
         case (s)
            0: begin drive(1'b0, 3'd2); sb.push_back('{"flush_capture", 32'h2004, 1'b1, 1'b0, 1'b0}); end
            1: begin flush = 1'b1; drive(1'b1, 3'd0); sb.push_back('{"flush_drop", 32'h2008, 1'b0, 1'b0, 1'b0}); end
            default: begin flush = 1'b0; drive(1'b1, 3'd0); sb.push_back('{"flush_after", 32'h200C, 1'b0, 1'b0, 1'b0}); end
         endcase
         tick();
         e = sb.pop_front();
         checks++;
         if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
            errors++;
            $display("FAIL %s: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                     e.tag, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
         end
      end
   endtask

   task automatic test_sel_err();
      // PC is 0x200C on entry.
      set_target(5, 32'h700);
      for (int s = 0; s < 4; s++) begin
         case (s)
            0: begin drive(1'b1, 3'd7); sb.push_back('{"sel_err_7", 32'h200C, 1'b0, 1'b0, 1'b1}); end
            1: begin drive(1'b0, 3'd6); sb.push_back('{"sel_err_6", 32'h200C, 1'b0, 1'b0, 1'b1}); end
            2: begin drive(1'b0, 3'd0); sb.push_back('{"sel_err_end", 32'h200C, 1'b0, 1'b0, 1'b0}); end
            default: begin drive(1'b1, 3'd5); sb.push_back('{"sel_max_src", 32'h700, 1'b0, 1'b0, 1'b0}); end
         endcase
         tick();
         e = sb.pop_front();
         checks++;
         if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
            errors++;
            $display("FAIL %s: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                     e.tag, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
         end
      end
   endtask

   task automatic test_wrap();
      load_pc(32'hFFFF_FFFC);
      checks++;
      if ({pc, pc_4} !== {32'hFFFF_FFFC, 32'h0}) begin
         errors++;
         $display("FAIL wrap_pc4: pc=%h pc_4=%h, expected fffffffc 00000000", pc, pc_4);
      end
      drive(1'b1, 3'd0);
      sb.push_back('{"wrap_step", 32'h0, 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
         errors++;
         $display("FAIL %s: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                  e.tag, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
      end
   endtask

   task automatic test_async_reset();
      load_pc(32'h100);
      set_target(2, 32'h400);
      drive(1'b0, 3'd2);
      tick();
      checks++;
      if (pend_valid !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: pend=%b, expected 1", pend_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pc, pend_valid} !== {32'h0, 1'b0}) begin
         errors++;
         $display("FAIL areset_now: pc=%h pend=%b, expected 00000000 0", pc, pend_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 3'd0);
      sb.push_back('{"areset_after", 32'h4, 1'b0, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({pc, pend_valid, misalign, sel_err} !== {e.pc, e.pend, e.mis, e.sel}) begin
         errors++;
         $display("FAIL %s: pc=%h pend=%b mis=%b sel=%b, expected %h %b %b %b",
                  e.tag, pc, pend_valid, misalign, sel_err, e.pc, e.pend, e.mis, e.sel);
      end
   endtask

   initial begin
      test_reset();
      test_stall_redirect();
      test_misalign();
      test_trap();
      test_simultaneous();
      test_flush();
      test_sel_err();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
